// File: rtl/lsu_issue_pkg.sv
// Shared types and defaults for the LSU issue unit: FSM state encoding and
// the in-flight entry record kept per outstanding op.
package lsu_issue_pkg;

  localparam int DEFAULT_TAG_WIDTH = 10;
  localparam int DEFAULT_DEPTH     = 8;

  // Entry tags are stored at a fixed width so the struct can live here;
  // unused upper bits stay zero and are trimmed in synthesis.
  localparam int MAX_TAG_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND_INSTR,
    SEND_DATA
  } issue_state_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic                     is_write;
    logic [MAX_TAG_WIDTH-1:0] tag;
    logic [63:0]              value;
  } inflight_entry_t;

endpackage

// File: rtl/lsu_inflight_table.sv
// Circular buffer of in-flight ops: allocated in tag order, completed in any
// order, retired in order from the head.
module lsu_inflight_table
  import lsu_issue_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 alloc_is_write,
  input  logic                 comp_valid,
  input  logic [TAG_WIDTH-1:0] comp_tag,
  input  logic [63:0]          comp_value,
  input  logic                 retire,
  output logic                 full,
  output logic                 head_valid,
  output logic [TAG_WIDTH-1:0] head_tag,
  output logic                 head_is_write,
  output logic [63:0]          head_value,
  output logic                 tag_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  inflight_entry_t      entries [DEPTH];
  logic [IDX_W-1:0]     head_ptr;
  logic [CNT_W-1:0]     count;
  logic [IDX_W-1:0]     alloc_idx;
  logic [IDX_W-1:0]     comp_idx;
  logic                 comp_hit;
  logic                 retire_fire;

  assign alloc_idx = alloc_tag[IDX_W-1:0];
  assign comp_idx  = comp_tag[IDX_W-1:0];
  assign full      = (count == CNT_W'(DEPTH));

  // A completion is only trusted if it names a live, not-yet-done entry.
  assign comp_hit = comp_valid
                 && entries[comp_idx].busy
                 && !entries[comp_idx].done
                 && (entries[comp_idx].tag == MAX_TAG_WIDTH'(comp_tag));

  assign head_valid    = entries[head_ptr].busy && entries[head_ptr].done;
  assign head_tag      = entries[head_ptr].tag[TAG_WIDTH-1:0];
  assign head_is_write = entries[head_ptr].is_write;
  assign head_value    = entries[head_ptr].is_write ? 64'd0 : entries[head_ptr].value;
  assign retire_fire   = retire && head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head_ptr  <= '0;
      count     <= '0;
      tag_error <= 1'b0;
    end else begin
      if (retire_fire) begin
        entries[head_ptr].busy <= 1'b0;
        entries[head_ptr].done <= 1'b0;
        head_ptr               <= head_ptr + IDX_W'(1);
      end
      if (comp_hit) begin
        entries[comp_idx].done  <= 1'b1;
        entries[comp_idx].value <= comp_value;
      end else if (comp_valid) begin
        tag_error <= 1'b1;
      end
      if (alloc_valid) begin
        entries[alloc_idx].busy     <= 1'b1;
        entries[alloc_idx].done     <= 1'b0;
        entries[alloc_idx].is_write <= alloc_is_write;
        entries[alloc_idx].tag      <= MAX_TAG_WIDTH'(alloc_tag);
        entries[alloc_idx].value    <= 64'd0;
      end
      case ({alloc_valid, retire_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_issue_unit.sv
// Accepts upstream load/store ops, issues each as an instruction beat then a
// data beat, and returns responses in issue order as completions arrive.
module lsu_issue_unit
  import lsu_issue_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_N,
  input  logic                 cs_N,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic                 op_is_write,
  input  logic [63:0]          op_addr,
  input  logic [63:0]          op_value,
  output logic                 lsu_proc_instr_valid,
  output logic [TAG_WIDTH-1:0] lsu_proc_instr_tag,
  output logic                 lsu_proc_instr_is_write,
  input  logic                 lsu_proc_instr_ready,
  output logic                 lsu_proc_data_valid,
  output logic [TAG_WIDTH-1:0] lsu_proc_data_tag,
  output logic [63:0]          lsu_proc_addr,
  output logic [63:0]          lsu_proc_value,
  input  logic                 lsu_proc_data_ready,
  input  logic                 lsu_completion_valid,
  input  logic [63:0]          lsu_completion_value,
  input  logic [TAG_WIDTH-1:0] lsu_completion_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_is_write,
  output logic [63:0]          resp_value,
  output logic                 tag_error
);

  issue_state_t         state, state_next;
  logic [TAG_WIDTH-1:0] next_tag;
  logic [TAG_WIDTH-1:0] cur_tag;
  logic                 cur_is_write;
  logic [63:0]          cur_addr;
  logic [63:0]          cur_value;
  logic                 table_full;
  logic                 op_fire;

  assign op_fire = op_valid && op_ready;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (op_fire)              state_next = SEND_INSTR;
      SEND_INSTR: if (lsu_proc_instr_ready) state_next = SEND_DATA;
      SEND_DATA:  if (lsu_proc_data_ready)  state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  always_comb begin
    op_ready             = 1'b0;
    lsu_proc_instr_valid = 1'b0;
    lsu_proc_data_valid  = 1'b0;
    unique case (state)
      IDLE:       op_ready             = !cs_N && !table_full;
      SEND_INSTR: lsu_proc_instr_valid = 1'b1;
      SEND_DATA:  lsu_proc_data_valid  = 1'b1;
      default:    op_ready             = 1'b0;
    endcase
  end

  // The accepted op is held here so both beats present stable fields.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      next_tag     <= '0;
      cur_tag      <= '0;
      cur_is_write <= 1'b0;
      cur_addr     <= '0;
      cur_value    <= '0;
    end else if (op_fire) begin
      next_tag     <= next_tag + TAG_WIDTH'(1);
      cur_tag      <= next_tag;
      cur_is_write <= op_is_write;
      cur_addr     <= op_addr;
      cur_value    <= op_value;
    end
  end

  assign lsu_proc_instr_tag      = cur_tag;
  assign lsu_proc_instr_is_write = cur_is_write;
  assign lsu_proc_data_tag       = cur_tag;
  assign lsu_proc_addr           = cur_addr;
  assign lsu_proc_value          = cur_value;

  lsu_inflight_table #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) u_table (
    .clk            (clk),
    .rst_n          (rst_N),
    .alloc_valid    (op_fire),
    .alloc_tag      (next_tag),
    .alloc_is_write (op_is_write),
    .comp_valid     (lsu_completion_valid),
    .comp_tag       (lsu_completion_tag),
    .comp_value     (lsu_completion_value),
    .retire         (resp_ready),
    .full           (table_full),
    .head_valid     (resp_valid),
    .head_tag       (resp_tag),
    .head_is_write  (resp_is_write),
    .head_value     (resp_value),
    .tag_error      (tag_error)
  );

endmodule

// File: doc/lsu_issue_unit.md
LSU_ISSUE_UNIT -- requirements
Module: lsu_issue_unit

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 10, width of the transaction tag.
REQ-002 SHALL have parameter DEPTH, default 8, maximum number of in-flight ops; power of two, at most 2**TAG_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_N  input  1  asynchronous active-low reset.
REQ-005 cs_N  input  1  active-low enable; when high, no new op is accepted; completions are still absorbed.
REQ-006 op_valid / op_ready  input / output  1 / 1  upstream op handshake.
REQ-007 op_is_write, op_addr, op_value  input  1, 64, 64  upstream op fields.
REQ-008 lsu_proc_instr_valid, lsu_proc_instr_tag, lsu_proc_instr_is_write  output  1, TAG_WIDTH, 1  instruction channel.
REQ-009 lsu_proc_instr_ready  input  1  instruction channel accept.
REQ-010 lsu_proc_data_valid, lsu_proc_data_tag, lsu_proc_addr, lsu_proc_value  output  1, TAG_WIDTH, 64, 64  data channel.
REQ-011 lsu_proc_data_ready  input  1  data channel accept.
REQ-012 lsu_completion_valid, lsu_completion_value, lsu_completion_tag  input  1, 64, TAG_WIDTH  completion pulse; no backpressure.
REQ-013 resp_valid / resp_ready  output / input  1 / 1  in-order response handshake.
REQ-014 resp_tag, resp_is_write, resp_value  output  TAG_WIDTH, 1, 64  response fields.
REQ-015 tag_error  output  1  sticky flag for unmatched completion.

Function
REQ-016 Issue FSM states SHALL be IDLE, SEND_INSTR and SEND_DATA.
REQ-017 op_ready SHALL be combinational: (state==IDLE) && !cs_N && (count<DEPTH).
REQ-018 On op_valid&&op_ready the op SHALL be latched, get tag = next_tag, be allocated in entry next_tag[log2(DEPTH)-1:0], and move the FSM to SEND_INSTR; next_tag increments modulo 2**TAG_WIDTH.
REQ-019 In SEND_INSTR: instr_valid=1, with tag and is_write held stable until an edge with instr_ready=1, then SEND_DATA.
REQ-020 data_valid SHALL never assert before the instruction is accepted, and instr_valid and data_valid are never high together.
REQ-021 In SEND_DATA: data_valid=1, with tag, addr and value held stable until an edge with data_ready=1, then IDLE.
REQ-022 Peak issue rate SHALL be one op per 3 cycles with both readies held high.
REQ-023 On completion_valid, index = completion_tag low bits; if the entry is busy, its tag equals completion_tag and it is not done, then set done and store the value; otherwise set tag_error=1 (sticky) and change no entry.
REQ-024 A completion arriving while its op is still in SEND_DATA SHALL be accepted.
REQ-025 resp_valid SHALL equal head entry busy&&done; resp fields come from the head; resp_value is 0 for writes.
REQ-026 On resp_valid&&resp_ready the head SHALL be freed and advance (wraps at DEPTH), and count decrements.
REQ-027 Responses SHALL leave in issue order regardless of completion order.
REQ-028 Simultaneous allocate and retire SHALL leave count unchanged; completion and retire in the same cycle (different entries) both take effect.
REQ-029 When full (count==DEPTH), op_ready=0 until a retire.

Reset
REQ-030 Asserting rst_N low SHALL immediately clear: state=IDLE; all valids=0; all tag/data outputs=0; next_tag, head, count = 0; all entries not busy; tag_error=0.
REQ-031 Reset mid-transaction SHALL drop in-flight ops with no response emitted.

Structure
REQ-032 Package lsu_issue_pkg SHALL hold the FSM state enum, the in-flight entry struct (busy, done, is_write, tag, value) and default TAG_WIDTH/DEPTH.
REQ-033 The in-flight circular buffer SHALL be sub-module lsu_inflight_table; the FSM stays in lsu_issue_unit.

Verification
REQ-034 Write 0x1000 / 0xDEADBEEFCAFEF00D, readies high -> instr_valid 1 cycle, tag 0, then data_valid 1 cycle, tag 0; completion tag 0 -> resp tag 0, is_write=1, value 0.
REQ-035 Read 0x1000 -> tag 1; completion value 0xDEADBEEFCAFEF00D -> resp_value 0xDEADBEEFCAFEF00D.
REQ-036 8 ops, no completions -> op_ready=0 after the 8th; complete tags 7..0 -> responses 0..7 in order; op_ready returns after the first retire.
REQ-037 instr_ready low 5 cycles -> instr fields stable, data_valid=0 throughout.
REQ-038 Completion tag 0x3FF with table empty -> tag_error=1 and stays 1, no resp_valid; 1026 ops -> tags ...,1023,0,1 wrap.
REQ-039 rst_N low during SEND_DATA -> all valids 0 at once; after release, next op gets tag 0.
